pip_if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request/response sequencing, 1-entry fetch skid buffer, and the IF/ID pipeline register.
- Directly upstream of the ID-stage hazard/NPC control unit. Consumes that unit's flush (if_rst), stall (if_stall) and computed next PC (addr_out). Produces the IF/ID contents that the unit reads back as addr_in and instruction fields.

---
 rtl/pip_if_pkg.sv | 18 +
 rtl/pip_if_buf.sv | 40 ++++
 rtl/pip_if_stage.sv | 123 ++++++++++++
 tb/tb_pip_if_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pip_if_pkg.sv
// Shared constants and FSM encoding for the MIPS instruction-fetch stage.
package pip_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } if_state_e;

  // Sequential PC increment; wraps silently modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pip_if_buf.sv
// One-entry skid buffer catching a fetch response that lands while IF/ID is stalled.
module pip_if_buf
  import pip_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid_q <= 1'b0;
    else if (clear)   valid_q <= 1'b0;
    else if (load)    valid_q <= 1'b1;
    else if (drain)   valid_q <= 1'b0;
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      inst_q <= inst_in;
      pc4_q  <= pc4_in;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/pip_if_stage.sv
// IF stage: PC register, single-outstanding imem sequencing, skid buffer and IF/ID register.
module pip_if_stage
  import pip_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rst,
  input  logic        if_stall,
  input  logic [31:0] npc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic [31:0] pc_out
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc4;
  logic        accept;

  // Held low through reset so nothing is issued before the PC settles.
  assign imem_req  = rst_n & (state_q == ST_FETCH) & ~buf_valid;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign accept    = (state_q == ST_WAIT) & imem_rvalid & ~if_rst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_req && imem_gnt) begin
          if (if_rst) begin
            pc_d    = npc_in;
            state_d = ST_DISCARD;
          end else begin
            pc_d    = pc_plus4(pc_q);
            tag_d   = pc_q;
            state_d = ST_WAIT;
          end
        end else if (if_rst) begin
          pc_d = npc_in;
        end
      end
      ST_WAIT: begin
        if (if_rst) begin
          pc_d    = npc_in;
          state_d = imem_rvalid ? ST_FETCH : ST_DISCARD;
        end else if (imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (if_rst)      pc_d    = npc_in;
        if (imem_rvalid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      tag_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
    end
  end

  pip_if_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (if_stall & accept),
    .drain   (~if_rst & ~if_stall & buf_valid),
    .clear   (if_rst),
    .inst_in (imem_rdata),
    .pc4_in  (pc_plus4(tag_q)),
    .valid   (buf_valid),
    .inst    (buf_inst),
    .pc4     (buf_pc4)
  );

  // IF/ID register: flush, then stall, then buffered entry, then fresh response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= 32'd0;
    end else if (if_rst) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (if_stall) begin
      if_id_valid <= if_id_valid;
    end else if (buf_valid) begin
      if_id_valid <= 1'b1;
      if_id_inst  <= buf_inst;
      if_id_pc4   <= buf_pc4;
    end else if (accept) begin
      if_id_valid <= 1'b1;
      if_id_inst  <= imem_rdata;
      if_id_pc4   <= pc_plus4(tag_q);
    end else begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_pip_if_stage.sv
// Testbench for pip_if_stage: directed vector table, async-reset sequence, randomized run vs. model.
module tb_pip_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, if_rst, if_stall, imem_gnt, imem_rvalid;
  logic [31:0] npc_in, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_inst, if_id_pc4, pc_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pip_if_stage dut (
    .clk(clk), .rst_n(rst_n), .if_rst(if_rst), .if_stall(if_stall), .npc_in(npc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .pc_out(pc_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc4, input logic [31:0] pc, input logic req);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".inst"}, if_id_inst, inst);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".addr"}, imem_addr, pc);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
  endtask

  typedef struct {
    logic        rst, stall, gnt, rv;
    logic [31:0] rdata, npc;
    logic        e_v;
    logic [31:0] e_inst, e_pc4, e_pc;
    logic        e_req;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic stall, logic gnt, logic rv, logic [31:0] rdata,
                              logic [31:0] npc, logic e_v, logic [31:0] e_inst,
                              logic [31:0] e_pc4, logic [31:0] e_pc, logic e_req);
    vec_t v;
    v.rst = rst; v.stall = stall; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.npc = npc;
    v.e_v = e_v; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_pc = e_pc; v.e_req = e_req;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic [31:0] npc);
    if_rst = rst; if_stall = stall; imem_gnt = gnt; imem_rvalid = rv;
    imem_rdata = rdata; npc_in = npc;
  endtask

  // Behavioural reference: outstanding/doomed flags plus a queue for the skid entry.
  typedef struct {logic [31:0] inst; logic [31:0] pc4;} ent_t;
  ent_t        bq[$];
  logic [31:0] m_pc, m_tag, m_inst, m_pc4;
  logic        m_out, m_drop, m_v;

  task automatic model_reset();
    m_pc = 32'h3000; m_tag = 0; m_inst = NOP; m_pc4 = 0;
    m_out = 0; m_drop = 0; m_v = 0; bq.delete();
  endtask

  task automatic model_step(input logic rst, input logic stall, input logic gnt, input logic rv,
                            input logic [31:0] rdata, input logic [31:0] npc);
    logic req, resp_ok;
    ent_t e;
    req     = !m_out && bq.size() == 0;
    resp_ok = m_out && !m_drop && rv && !rst;
    if (rst) begin
      m_v = 0; m_inst = NOP; bq.delete();
    end else if (stall) begin
      if (resp_ok) begin e.inst = rdata; e.pc4 = m_tag + 32'd4; bq.push_back(e); end
    end else if (bq.size() != 0) begin
      e = bq.pop_front(); m_v = 1; m_inst = e.inst; m_pc4 = e.pc4;
    end else if (resp_ok) begin
      m_v = 1; m_inst = rdata; m_pc4 = m_tag + 32'd4;
    end else begin
      m_v = 0; m_inst = NOP;
    end
    if (rv && m_out) m_out = 0;
    if (req && gnt) begin
      m_out = 1; m_drop = rst; m_tag = m_pc;
    end else if (rst && m_out) begin
      m_drop = 1;
    end
    if (rst) m_pc = npc;
    else if (req && gnt) m_pc = m_pc + 32'd4;
  endtask

  initial begin
    logic        pend, rv, gnt, rst, stall, pre_req;
    logic [31:0] maddr, rdata, npc, pre_addr;
    int          cnt;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 0, NOP, 0, 32'h3000, 0);
    @(negedge clk) rst_n = 1'b1;

    // rdata mirrors the fetch address; expectations are values after each edge.
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,0,32'h3004,0));
    tbl.push_back(mk(0,0,0,1,32'h3000,0,          1,32'h3000,32'h3004,32'h3004,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h3004,32'h3008,0));
    tbl.push_back(mk(0,0,0,1,32'h3004,0,          1,32'h3004,32'h3008,32'h3008,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h3008,32'h300C,0));
    tbl.push_back(mk(0,0,0,1,32'h3008,0,          1,32'h3008,32'h300C,32'h300C,1));
    tbl.push_back(mk(0,1,1,0,0,0,                 1,32'h3008,32'h300C,32'h3010,0));
    tbl.push_back(mk(0,1,0,1,32'h300C,0,          1,32'h3008,32'h300C,32'h3010,0));
    tbl.push_back(mk(0,1,1,0,0,0,                 1,32'h3008,32'h300C,32'h3010,0));
    tbl.push_back(mk(0,0,1,0,0,0,                 1,32'h300C,32'h3010,32'h3010,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h3010,32'h3014,0));
    tbl.push_back(mk(1,0,0,0,0,32'h3040,          0,NOP,32'h3010,32'h3040,0));
    tbl.push_back(mk(0,0,0,0,0,0,                 0,NOP,32'h3010,32'h3040,0));
    tbl.push_back(mk(0,0,0,1,32'hDEAD_BEEF,0,     0,NOP,32'h3010,32'h3040,1));
    tbl.push_back(mk(1,0,1,0,0,32'h3080,          0,NOP,32'h3010,32'h3080,0));
    tbl.push_back(mk(0,0,0,1,32'hBAD0_0001,0,     0,NOP,32'h3010,32'h3080,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h3010,32'h3084,0));
    tbl.push_back(mk(0,0,0,1,32'h1111_1111,0,     1,32'h1111_1111,32'h3084,32'h3084,1));
    tbl.push_back(mk(0,1,1,0,0,0,                 1,32'h1111_1111,32'h3084,32'h3088,0));
    tbl.push_back(mk(0,1,0,1,32'h2222_2222,0,     1,32'h1111_1111,32'h3084,32'h3088,0));
    tbl.push_back(mk(1,1,0,0,0,32'h30C0,          0,NOP,32'h3084,32'h30C0,1));
    tbl.push_back(mk(0,0,0,0,0,0,                 0,NOP,32'h3084,32'h30C0,1));
    tbl.push_back(mk(1,0,0,0,0,32'hFFFF_FFFC,     0,NOP,32'h3084,32'hFFFF_FFFC,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h3084,32'h0000_0000,0));
    tbl.push_back(mk(0,0,0,1,32'h4444_4444,0,     1,32'h4444_4444,32'h0,32'h0,1));
    tbl.push_back(mk(0,0,1,0,0,0,                 0,NOP,32'h0,32'h4,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stall, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].npc);
      @(posedge clk);
      #1 chk_out($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_inst, tbl[i].e_pc4,
                 tbl[i].e_pc, tbl[i].e_req);
    end

    // Async reset while WAIT is pending, then a stale rvalid after release.
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, NOP, 0, 32'h3000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'h3333_3333, 0);
    @(posedge clk);
    #1 chk_out("stale_rv", 0, NOP, 0, 32'h3000, 1);
    @(negedge clk) drive(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1 chk_out("post_rst_fetch", 0, NOP, 0, 32'h3004, 0);

    // Randomized run with a variable-latency single-outstanding memory.
    @(negedge clk) rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    pend = 0; cnt = 0; maddr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rv    = pend && cnt == 0;
      rdata = {maddr[15:0] ^ 16'h5A5A, maddr[31:16]} ^ $urandom;
      gnt   = ($urandom_range(0, 9) < 6);
      rst   = ($urandom_range(0, 19) == 0);
      stall = ($urandom_range(0, 3) == 0);
      npc   = $urandom;
      drive(rst, stall, gnt, rv, rdata, npc);
      #1;
      pre_req = imem_req; pre_addr = imem_addr;
      chk("rnd.req", {31'd0, pre_req}, {31'd0, (!m_out && bq.size() == 0)});
      chk("rnd.addr", pre_addr, m_pc);
      @(posedge clk);
      model_step(rst, stall, gnt, rv, rdata, npc);
      if (rv) pend = 0;
      else if (pend) cnt--;
      if (pre_req && gnt) begin
        pend = 1; cnt = $urandom_range(0, 2); maddr = pre_addr;
      end
      #1;
      chk("rnd.valid", {31'd0, if_id_valid}, {31'd0, m_v});
      chk("rnd.inst", if_id_inst, m_inst);
      if (m_v) chk("rnd.pc4", if_id_pc4, m_pc4);
      chk("rnd.pc", pc_out, m_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
